// File: rtl/pipe_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage RV32I pipeline.
// Tracks EX/MEM/WB in a shadow scoreboard and drives stall, bubble, flush, forwarding and drain.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dec_valid,
    input  logic [4:0]       i_dec_rs1,
    input  logic [4:0]       i_dec_rs2,
    input  logic             i_dec_use_rs1,
    input  logic             i_dec_use_rs2,
    input  logic [4:0]       i_dec_rd,
    input  logic             i_dec_reg_write,
    input  logic             i_dec_mem_read,
    input  logic             i_dec_halt,
    input  logic             i_dec_trap,
    input  logic             i_ex_redirect,
    input  logic             i_mem_busy,
    output logic             o_stall_if_id,
    output logic             o_bubble_ex,
    output logic             o_flush_if_id,
    output logic             o_freeze,
    output logic [1:0]       o_fwd_rs1,
    output logic [1:0]       o_fwd_rs2,
    output logic             o_halted,
    output logic             o_trap,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [2:0] {RUN, DRAIN_H, DRAIN_T, HALTED, TRAPPED} state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } sb_ent_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t  state, state_nxt;
    sb_ent_t sb_ex, sb_mem, sb_wb, sb_ex_nxt;

    logic hit_ex1, hit_ex2, hit_mem1, hit_mem2;
    logic frozen, redirect, load_use, running, issue, drained;
    logic sb_wb_unused;

    function automatic logic hit(input sb_ent_t e, input logic [4:0] rs, input logic rd_en);
        return e.v & e.wr & (e.rd == rs) & (rs != 5'd0) & rd_en;
    endfunction

    // WB needs no forwarding (write-through regfile); it is kept only as scoreboard state.
    assign sb_wb_unused = ^sb_wb;

    assign hit_ex1  = hit(sb_ex,  i_dec_rs1, i_dec_use_rs1);
    assign hit_ex2  = hit(sb_ex,  i_dec_rs2, i_dec_use_rs2);
    assign hit_mem1 = hit(sb_mem, i_dec_rs1, i_dec_use_rs1);
    assign hit_mem2 = hit(sb_mem, i_dec_rs2, i_dec_use_rs2);

    assign frozen   = i_mem_busy;
    assign redirect = i_ex_redirect & ~frozen;
    assign load_use = (hit_ex1 | hit_ex2) & sb_ex.ld;
    assign running  = (state == RUN);

    assign o_freeze      = frozen;
    assign o_flush_if_id = redirect;
    assign o_fwd_rs1     = hit_ex1 ? 2'b01 : (hit_mem1 ? 2'b10 : 2'b00);
    assign o_fwd_rs2     = hit_ex2 ? 2'b01 : (hit_mem2 ? 2'b10 : 2'b00);
    assign o_halted      = (state == HALTED);
    assign o_trap        = (state == TRAPPED);

    always_comb begin
        o_stall_if_id = 1'b1;
        o_bubble_ex   = 1'b1;
        if (running) begin
            // A redirect squashes the ID instruction, so its load-use stall is moot.
            o_stall_if_id = frozen | (load_use & ~redirect);
            o_bubble_ex   = redirect | load_use;
        end
    end

    assign issue = i_dec_valid & ~o_stall_if_id & ~o_bubble_ex & ~redirect & running;

    always_comb begin
        sb_ex_nxt = '0;
        if (issue) begin
            sb_ex_nxt.v  = 1'b1;
            sb_ex_nxt.rd = i_dec_rd;
            sb_ex_nxt.wr = i_dec_reg_write;
            sb_ex_nxt.ld = i_dec_mem_read;
        end
    end

    // Drain completes on the advance that leaves EX, MEM and WB all empty.
    assign drained = ~sb_ex_nxt.v & ~sb_ex.v & ~sb_mem.v;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (issue && i_dec_halt)      state_nxt = DRAIN_H;
                else if (issue && i_dec_trap) state_nxt = DRAIN_T;
            end
            DRAIN_H: if (drained) state_nxt = HALTED;
            DRAIN_T: if (drained) state_nxt = TRAPPED;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= RUN;
            sb_ex       <= '0;
            sb_mem      <= '0;
            sb_wb       <= '0;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else if (!frozen) begin
            state  <= state_nxt;
            sb_ex  <= sb_ex_nxt;
            sb_mem <= sb_ex;
            sb_wb  <= sb_mem;
            if (running && load_use && !redirect && !(&o_stall_cnt))
                o_stall_cnt <= o_stall_cnt + CNT_ONE;
            if (redirect && !(&o_flush_cnt))
                o_flush_cnt <= o_flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a pipeline-occupancy reference model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             i_clk, i_rst;
    logic             i_dec_valid, i_dec_use_rs1, i_dec_use_rs2;
    logic [4:0]       i_dec_rs1, i_dec_rs2, i_dec_rd;
    logic             i_dec_reg_write, i_dec_mem_read, i_dec_halt, i_dec_trap;
    logic             i_ex_redirect, i_mem_busy;
    logic             o_stall_if_id, o_bubble_ex, o_flush_if_id, o_freeze;
    logic [1:0]       o_fwd_rs1, o_fwd_rs2;
    logic             o_halted, o_trap;
    logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_dec_valid(i_dec_valid), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
        .i_dec_use_rs1(i_dec_use_rs1), .i_dec_use_rs2(i_dec_use_rs2),
        .i_dec_rd(i_dec_rd), .i_dec_reg_write(i_dec_reg_write),
        .i_dec_mem_read(i_dec_mem_read), .i_dec_halt(i_dec_halt), .i_dec_trap(i_dec_trap),
        .i_ex_redirect(i_ex_redirect), .i_mem_busy(i_mem_busy),
        .o_stall_if_id(o_stall_if_id), .o_bubble_ex(o_bubble_ex),
        .o_flush_if_id(o_flush_if_id), .o_freeze(o_freeze),
        .o_fwd_rs1(o_fwd_rs1), .o_fwd_rs2(o_fwd_rs2),
        .o_halted(o_halted), .o_trap(o_trap),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a list of in-flight instructions (index 0 = youngest, in EX)
    // plus a simple run/drain/terminal mode.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } ent_t;

    ent_t        pipe[3];
    int          mode;         // 0 run, 1 drain-halt, 2 drain-trap, 3 halted, 4 trapped
    int unsigned m_scnt, m_fcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input ent_t e, input bit [4:0] rs, input bit rd_en);
        return e.v && e.wr && e.rd == rs && rs != 0 && rd_en;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
        mode = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic drive(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                         input bit u2, input bit [4:0] rd, input bit wr, input bit ld,
                         input bit halt, input bit trap, input bit redir, input bit busy);
        i_dec_valid = v; i_dec_rs1 = rs1; i_dec_use_rs1 = u1; i_dec_rs2 = rs2;
        i_dec_use_rs2 = u2; i_dec_rd = rd; i_dec_reg_write = wr; i_dec_mem_read = ld;
        i_dec_halt = halt; i_dec_trap = trap; i_ex_redirect = redir; i_mem_busy = busy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called at the falling edge with inputs applied: check outputs, then move the model
    // and the DUT across one rising edge, returning at the next falling edge.
    task automatic step();
        bit frz, redir, lu, e_st, e_bub, iss;
        bit [1:0] f1, f2;
        ent_t nw;
        #1;
        frz   = i_mem_busy;
        redir = i_ex_redirect && !frz;
        lu    = (hit(pipe[0], i_dec_rs1, i_dec_use_rs1) || hit(pipe[0], i_dec_rs2, i_dec_use_rs2))
                && pipe[0].ld;
        f1 = hit(pipe[0], i_dec_rs1, i_dec_use_rs1) ? 2'd1 : hit(pipe[1], i_dec_rs1, i_dec_use_rs1) ? 2'd2 : 2'd0;
        f2 = hit(pipe[0], i_dec_rs2, i_dec_use_rs2) ? 2'd1 : hit(pipe[1], i_dec_rs2, i_dec_use_rs2) ? 2'd2 : 2'd0;
        if (mode == 0) begin
            e_st  = frz || (lu && !redir);
            e_bub = redir || lu;
        end else begin
            e_st  = 1;
            e_bub = 1;
        end
        iss = i_dec_valid && !e_st && !e_bub && !redir && mode == 0;
        chk("stall",    o_stall_if_id, e_st);
        chk("bubble",   o_bubble_ex,   e_bub);
        chk("flush",    o_flush_if_id, redir);
        chk("freeze",   o_freeze,      frz);
        chk("fwd_rs1",  o_fwd_rs1,     f1);
        chk("fwd_rs2",  o_fwd_rs2,     f2);
        chk("halted",   o_halted,      mode == 3);
        chk("trap",     o_trap,        mode == 4);
        chk("stall_cnt", o_stall_cnt,  m_scnt);
        chk("flush_cnt", o_flush_cnt,  m_fcnt);
        if (!frz) begin
            if (mode == 0 && lu && !redir) m_scnt++;
            if (redir) m_fcnt++;
            nw = iss ? '{1, i_dec_rd, i_dec_reg_write, i_dec_mem_read} : '{0, 0, 0, 0};
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nw;
            if (mode == 0 && iss && i_dec_halt)      mode = 1;
            else if (mode == 0 && iss && i_dec_trap) mode = 2;
            else if ((mode == 1 || mode == 2) && !pipe[0].v && !pipe[1].v && !pipe[2].v)
                mode = mode + 2;
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Asserts reset at the current time and checks the asynchronous clear right away.
    task automatic do_reset(input string tag);
        idle();
        i_rst = 1;
        #1;
        chk({tag, "_stall"}, o_stall_if_id, 0);
        chk({tag, "_bubble"}, o_bubble_ex, 0);
        chk({tag, "_flush"}, o_flush_if_id, 0);
        chk({tag, "_fwd"}, {o_fwd_rs1, o_fwd_rs2}, 0);
        chk({tag, "_flags"}, {o_halted, o_trap, o_freeze}, 0);
        chk({tag, "_scnt"}, o_stall_cnt, 0);
        chk({tag, "_fcnt"}, o_flush_cnt, 0);
        model_reset();
        @(negedge i_clk);
        i_rst = 0;
        @(negedge i_clk);
    endtask

    initial begin
        idle();
        i_rst = 0;
        model_reset();
        @(negedge i_clk);
        do_reset("rst0");

        // Load x5 followed by a reader of x5.
        drive(1, 1, 1, 2, 1, 5, 1, 1, 0, 0, 0, 0); step();
        drive(1, 5, 1, 6, 1, 7, 1, 0, 0, 0, 0, 0); step();
        chk("lu_fwd_mem", o_fwd_rs1, 2'b10);
        chk("lu_scnt", o_stall_cnt, 1);
        chk("lu_nostall", o_stall_if_id, 0);
        step();

        // ALU result forwarding from EX, then from MEM.
        do_reset("rst1");
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0); step();
        drive(1, 4, 1, 3, 1, 8, 1, 0, 0, 0, 0, 0);
        #1 chk("fwd_ex", o_fwd_rs2, 2'b01);
        step();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0); step();
        drive(1, 9, 1, 10, 1, 7, 1, 0, 0, 0, 0, 0); step();
        drive(1, 4, 1, 3, 1, 8, 1, 0, 0, 0, 0, 0);
        #1 chk("fwd_mem", o_fwd_rs2, 2'b10);
        step();

        // x0 never forwards or stalls.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
        drive(1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0);
        #1 chk("x0_fwd", {o_fwd_rs1, o_fwd_rs2}, 0);
        chk("x0_stall", o_stall_if_id, 0);
        step();

        // Redirect coinciding with a load-use hazard.
        do_reset("rst2");
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0); step();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0);
        #1 chk("rd_flush", {o_flush_if_id, o_bubble_ex, o_stall_if_id}, 3'b110);
        step();
        chk("rd_fcnt", o_flush_cnt, 1);
        chk("rd_scnt", o_stall_cnt, 0);
        idle(); step();

        // Redirect while frozen waits for the first unfrozen cycle.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        chk("frz_fcnt", o_flush_cnt, 2);

        // Halt with instructions in flight and a 2-cycle freeze mid-drain.
        do_reset("rst3");
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
        idle(); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step(); step();
        idle(); step();
        chk("halt_pre", o_halted, 0);
        step();
        chk("halt_set", o_halted, 1);
        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step();
        chk("halt_hold", {o_halted, o_stall_if_id, o_bubble_ex}, 3'b111);

        // Trap drains to the sticky trap flag.
        do_reset("rst4");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
        idle();
        for (int k = 0; k < 3; k++) step();
        chk("trap_set", o_trap, 1);
        step();

        // Reset in the middle of a trap drain.
        do_reset("rst5");
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0); step();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0); step(); step();
        idle(); step();
        chk("mid_drain", o_stall_if_id, 1);
        do_reset("rst6");

        // Randomized traffic: small register range keeps hazards frequent.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0,
                  0, 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
            step();
        end

        // Random traffic ending in a halt somewhere along the way.
        do_reset("rst7");
        for (int n = 0; n < 60; n++) begin
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  n > 40 && $urandom_range(0, 3) == 0, n > 40 && $urandom_range(0, 3) == 0,
                  0, $urandom_range(0, 5) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
